// File: rtl/fifo_mac.sv
// Pops paired operands from FIFOs A and B, accumulates LEN products; FIFO_MAC_SAT_EN selects saturating accumulation.
// Latency: last pop at cycle t, final accumulate in t+1, done pulse at t+2.
// Backpressure: an empty flag on either FIFO stalls both pops; stalls only add bubbles.
module fifo_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int LEN        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  a_empty,
    input  logic                  b_empty,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  a_rden,
    output logic                  b_rden,
    output logic [ACC_WIDTH-1:0]  acc,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    localparam int CW = $clog2(LEN + 1);
    localparam logic [CW-1:0] LEN_C = CW'(LEN);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [CW-1:0]           issued_q, issued_d;
    logic [CW-1:0]           issued_inc;
    logic                    vld_q, vld_d;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic                    pop;
    logic [2*DATA_WIDTH-1:0] prod;

    // Pops are gated by rst so nothing leaves the FIFOs while the block is held in reset.
    assign pop        = (state_q == S_RUN) && !rst && !a_empty && !b_empty && (issued_q < LEN_C);
    assign issued_inc = issued_q + CW'(1);
    assign prod       = {{DATA_WIDTH{1'b0}}, a_data} * {{DATA_WIDTH{1'b0}}, b_data};

`ifdef FIFO_MAC_SAT_EN
    logic                 ovf_q, ovf_d;
    logic [ACC_WIDTH:0]   sum;

    assign sum = {1'b0, acc_q} + (ACC_WIDTH + 1)'(prod);
    assign ovf = ovf_q;
`else
    logic [ACC_WIDTH-1:0] sum;

    assign sum = acc_q + ACC_WIDTH'(prod);
    assign ovf = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        issued_d = issued_q;
        vld_d    = pop;
        acc_d    = acc_q;
`ifdef FIFO_MAC_SAT_EN
        ovf_d    = ovf_q;
`endif

        // Read data arrives the cycle after the pop, so accumulation trails issue by one.
        if (vld_q) begin
`ifdef FIFO_MAC_SAT_EN
            if (sum[ACC_WIDTH]) begin
                acc_d = '1;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum[ACC_WIDTH-1:0];
            end
`else
            acc_d = sum;
`endif
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    issued_d = '0;
                    acc_d    = '0;
`ifdef FIFO_MAC_SAT_EN
                    ovf_d    = 1'b0;
`endif
                end
            end
            S_RUN: begin
                if (pop) begin
                    issued_d = issued_inc;
                    if (issued_inc == LEN_C) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            issued_q <= '0;
            vld_q    <= 1'b0;
            acc_q    <= '0;
`ifdef FIFO_MAC_SAT_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            vld_q    <= vld_d;
            acc_q    <= acc_d;
`ifdef FIFO_MAC_SAT_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign a_rden = pop;
    assign b_rden = pop;
    assign acc    = acc_q;
    assign busy   = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_fifo_mac.sv
// Bench for fifo_mac: queue-backed FIFO models, a table of directed runs, randomized stalled runs
// checked against an arithmetic model, and hand sequences for reset abort and ignored starts.
module tb_fifo_mac;

    localparam int DW  = 8;
    localparam int AW  = 16;
    localparam int LEN = 8;
`ifdef FIFO_MAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          a_empty, b_empty;
    logic [DW-1:0] a_data, b_data;
    logic          a_rden, b_rden;
    logic [AW-1:0] acc;
    logic          busy, done, ovf;

    always #5 clk = ~clk;

    fifo_mac #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN(LEN)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_empty(a_empty), .b_empty(b_empty),
        .a_data(a_data), .b_data(b_data),
        .a_rden(a_rden), .b_rden(b_rden),
        .acc(acc), .busy(busy), .done(done), .ovf(ovf)
    );

    int tests = 0;
    int fails = 0;

    int a_q[$];
    int b_q[$];
    int va[LEN];
    int vb[LEN];
    int stall_after = -1;
    int b_hold = 0;
    int pop_cnt = 0;
    bit rnd_stall = 1'b0;
    bit drv_ra, drv_rb;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // FIFO models: pop on an observed strobe, present the popped word the following cycle.
    initial begin
        a_data  = '0;
        b_data  = '0;
        a_empty = 1'b1;
        b_empty = 1'b1;
        forever begin
            @(negedge clk);
            drv_ra = a_rden;
            drv_rb = b_rden;
            @(posedge clk);
            #1;
            if (drv_ra && a_q.size() > 0) a_data = DW'(a_q.pop_front());
            if (drv_rb && b_q.size() > 0) begin
                b_data = DW'(b_q.pop_front());
                pop_cnt++;
                if (pop_cnt == stall_after) b_hold = 3;
            end
            a_empty = (a_q.size() == 0) || (rnd_stall && $urandom_range(0, 2) == 0);
            b_empty = (b_q.size() == 0) || (b_hold > 0) || (rnd_stall && $urandom_range(0, 2) == 0);
            if (b_hold > 0) b_hold--;
        end
    end

    task automatic load();
        a_q.delete();
        b_q.delete();
        for (int i = 0; i < LEN; i++) begin
            a_q.push_back(va[i]);
            b_q.push_back(vb[i]);
        end
        pop_cnt = 0;
    endtask

    // Sum of products straight from the operand lists, wrapping or clamping at 2^AW.
    task automatic model(output longint e_acc, output bit e_ovf);
        longint s = 0;
        longint top = (longint'(1) << AW) - 1;
        e_ovf = 1'b0;
        for (int i = 0; i < LEN; i++) begin
            s = s + longint'(va[i]) * longint'(vb[i]);
            if (SAT) begin
                if (s > top) begin
                    s = top;
                    e_ovf = 1'b1;
                end
            end else begin
                s = s % (top + 1);
            end
        end
        e_acc = s;
    endtask

    task automatic run(input int budget, input int extra_start_cyc, input bit start_on_done,
                       output int pops, output int first_pop, output int last_pop,
                       output int done_cyc, output int done_cnt,
                       output logic [AW-1:0] acc_at_done, output logic ovf_at_done, output int viol);
        pops = 0; first_pop = -1; last_pop = -1; done_cyc = -1; done_cnt = 0;
        acc_at_done = '0; ovf_at_done = 1'b0; viol = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if ((a_rden != b_rden) || (a_rden && (a_empty || b_empty))) viol++;
            if (a_rden) begin
                pops++;
                if (first_pop < 0) first_pop = c;
                last_pop = c;
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
                acc_at_done = acc;
                ovf_at_done = ovf;
                if (start_on_done) start = 1'b1;
            end
            if (c == extra_start_cyc) start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            if (done_cnt > 0 && c >= done_cyc + 3) break;
        end
    endtask

    typedef struct {
        int     a0;
        int     ainc;
        int     bv;
        int     stall;
        longint acc_w;
        longint acc_s;
        bit     ovf_s;
    } vec_t;

    vec_t vecs[6];

    int pops, first_pop, last_pop, done_cyc, done_cnt, viol;
    logic [AW-1:0] acc_d;
    logic ovf_d;
    longint e_acc;
    bit e_ovf;
    int n_pop, n_done;

    initial begin
        vecs[0] = '{a0: 1,   ainc: 1,  bv: 2,   stall: -1, acc_w: 72,    acc_s: 72,    ovf_s: 0};
        vecs[1] = '{a0: 1,   ainc: 1,  bv: 2,   stall: 4,  acc_w: 72,    acc_s: 72,    ovf_s: 0};
        vecs[2] = '{a0: 255, ainc: 0,  bv: 255, stall: -1, acc_w: 61448, acc_s: 65535, ovf_s: 1};
        vecs[3] = '{a0: 0,   ainc: 0,  bv: 200, stall: -1, acc_w: 0,     acc_s: 0,     ovf_s: 0};
        vecs[4] = '{a0: 10,  ainc: 10, bv: 3,   stall: -1, acc_w: 1080,  acc_s: 1080,  ovf_s: 0};
        vecs[5] = '{a0: 200, ainc: 5,  bv: 250, stall: 7,  acc_w: 41784, acc_s: 65535, ovf_s: 1};

        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_acc", acc, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ovf", ovf, 0);
        check("reset_rden", a_rden | b_rden, 0);
        @(posedge clk); #1 rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < LEN; i++) begin
                va[i] = vecs[v].a0 + i * vecs[v].ainc;
                vb[i] = vecs[v].bv;
            end
            stall_after = vecs[v].stall;
            load();
            run(60, -1, 1'b0, pops, first_pop, last_pop, done_cyc, done_cnt, acc_d, ovf_d, viol);
            check($sformatf("vec%0d_acc", v), acc_d, SAT ? vecs[v].acc_s : vecs[v].acc_w);
            check($sformatf("vec%0d_ovf", v), ovf_d, SAT ? vecs[v].ovf_s : 1'b0);
            check($sformatf("vec%0d_pops", v), pops, LEN);
            check($sformatf("vec%0d_first_pop", v), first_pop, 1);
            check($sformatf("vec%0d_done_cnt", v), done_cnt, 1);
            check($sformatf("vec%0d_done_lat", v), done_cyc - last_pop, 2);
            check($sformatf("vec%0d_done_cyc", v), done_cyc, (vecs[v].stall > 0) ? 13 : 10);
            check($sformatf("vec%0d_viol", v), viol, 0);
            check($sformatf("vec%0d_busy_after", v), busy, 0);
        end
        stall_after = -1;

        rnd_stall = 1'b1;
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < LEN; i++) begin
                va[i] = $urandom_range(0, 255);
                vb[i] = $urandom_range(0, 255);
            end
            load();
            model(e_acc, e_ovf);
            run(100, -1, 1'b0, pops, first_pop, last_pop, done_cyc, done_cnt, acc_d, ovf_d, viol);
            check($sformatf("rnd%0d_acc", r), acc_d, e_acc);
            check($sformatf("rnd%0d_ovf", r), ovf_d, e_ovf);
            check($sformatf("rnd%0d_pops", r), pops, LEN);
            check($sformatf("rnd%0d_done_cnt", r), done_cnt, 1);
            check($sformatf("rnd%0d_done_lat", r), done_cyc - last_pop, 2);
            check($sformatf("rnd%0d_viol", r), viol, 0);
        end
        rnd_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset after the fourth pop aborts the run and discards the in-flight product.
        for (int i = 0; i < LEN; i++) begin
            va[i] = i + 1;
            vb[i] = 2;
        end
        load();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n_pop = 0;
        for (int c = 0; c < 30 && n_pop < 4; c++) begin
            @(negedge clk);
            if (a_rden) n_pop++;
        end
        check("abort_pops_before", n_pop, 4);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("abort_rden_in_rst", a_rden | b_rden, 0);
        @(posedge clk); #1 rst = 1'b0;
        n_pop = 0;
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (a_rden || b_rden) n_pop++;
            if (done) n_done++;
        end
        check("abort_pops_after", n_pop, 0);
        check("abort_done", n_done, 0);
        check("abort_busy", busy, 0);
        check("abort_acc", acc, 0);
        @(posedge clk); #1;

        // Starts during RUN and in the DONE cycle are ignored; a later start clears acc.
        load();
        run(60, 3, 1'b1, pops, first_pop, last_pop, done_cyc, done_cnt, acc_d, ovf_d, viol);
        check("ign_pops", pops, LEN);
        check("ign_acc", acc_d, 72);
        check("ign_done_cyc", done_cyc, 10);
        for (int i = 0; i < LEN; i++) vb[i] = 1;
        load();
        n_pop = 0;
        n_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (a_rden || busy) n_pop++;
            if (done) n_done++;
        end
        check("ign_idle_activity", n_pop, 0);
        check("ign_idle_done", n_done, 0);
        check("ign_acc_hold", acc, 72);
        @(posedge clk); #1;
        run(60, -1, 1'b0, pops, first_pop, last_pop, done_cyc, done_cnt, acc_d, ovf_d, viol);
        check("restart_pops", pops, LEN);
        check("restart_acc", acc_d, 36);
        check("restart_done_cnt", done_cnt, 1);
        check("restart_viol", viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_mac.md
FIFO_MAC -- requirements
Module: fifo_mac

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each operand popped from the upstream FIFOs.
REQ-002 Parameter ACC_WIDTH, default 24: accumulator width; SHALL be at least 2*DATA_WIDTH.
REQ-003 Parameter LEN, default 8: operand pairs consumed per run; SHALL be at least 1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to begin a run; sampled only in IDLE.
REQ-007 a_empty, b_empty  input  1 each  empty flags of operand FIFOs A and B.
REQ-008 a_data, b_data  input  DATA_WIDTH each  FIFO read data, valid the cycle after the corresponding rden.
REQ-009 a_rden, b_rden  output  1 each  FIFO pop strobes; always equal to each other.
REQ-010 acc  output  ACC_WIDTH  accumulated sum of products.
REQ-011 busy  output  1  high in RUN and DRAIN.
REQ-012 done  output  1  one-cycle pulse when a run's final product has been accumulated.
REQ-013 ovf  output  1  sticky overflow flag (see Configuration).

Function
REQ-014 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-015 IDLE + start=1 -> RUN next cycle; acc, ovf, issue counter cleared on that edge.
REQ-016 In RUN, a_rden=b_rden=1 combinationally iff !a_empty && !b_empty && issued<LEN; otherwise both 0.
REQ-017 No pop SHALL be issued when either FIFO is empty; a pop of one FIFO without the other is forbidden.
REQ-018 Each pop increments the issue counter; the pop making issued==LEN moves RUN -> DRAIN.
REQ-019 A registered valid SHALL follow each pop by one cycle; in that cycle acc <= acc + zero-extended unsigned a_data*b_data.
REQ-020 DRAIN lasts exactly one cycle (the final accumulate), then -> DONE.
REQ-021 DONE lasts one cycle with done=1, then -> IDLE; acc holds until the next start.
REQ-022 start outside IDLE SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-023 Latency: last pop at cycle t -> final acc visible at t+1 -> done=1 at t+2.
REQ-024 Stalls (empty in RUN) SHALL insert bubbles only; result identical to unstalled run.
REQ-025 Without saturation, accumulation wraps modulo 2^ACC_WIDTH.

Reset
REQ-026 rst=1 at a clock edge: state IDLE, acc=0, ovf=0, issue counter 0, valid 0, done=0, busy=0.
REQ-027 a_rden/b_rden SHALL be 0 during any cycle with rst=1 and the cycle after.
REQ-028 Reset mid-run SHALL abort the run with no done pulse; in-flight product discarded.

Configuration
REQ-029 Macro FIFO_MAC_SAT_EN defined: a sum exceeding 2^ACC_WIDTH-1 clamps acc to all ones and sets ovf=1 until next start or rst.
REQ-030 Macro FIFO_MAC_SAT_EN undefined: acc wraps per REQ-025 and ovf is tied 0.

Verification
REQ-031 LEN=8, A=1..8, B=2 each, both FIFOs pre-filled, start -> 8 consecutive pop cycles, acc=72, done one pulse 2 cycles after last pop.
REQ-032 Same data, B empty for 3 cycles after 4th pop -> no pops during stall, acc=72, done 3 cycles later than REQ-031.
REQ-033 ACC_WIDTH=16, LEN=8, A=B=255 -> without macro acc=61448, ovf=0; with FIFO_MAC_SAT_EN acc=65535, ovf=1.
REQ-034 rst asserted after 4th pop of REQ-031 run -> acc=0, busy=0, no done, no further pops until new start.
REQ-035 start pulsed during RUN and in DONE cycle -> ignored; start in following IDLE -> acc cleared, new run of exactly LEN pops.
